// File: rtl/event_priority_encoder.sv
// -----------------------------------------------------------------------------
// event_priority_encoder
//
// Captures event pulses on N request lines into a pending vector and hands
// them, one index at a time, to a single consumer over a valid/ready output.
// Selecting an index clears its pending bit. Priority is fixed (highest index
// wins) when RR = 0, or round-robin when RR = 1.
//
// Ports:
//   clk        in   1  clock, all state updates on the rising edge
//   rst        in   1  synchronous active-high reset
//   req        in   N  event lines, sampled every cycle
//   out_idx    out  W  index of the presented event
//   out_valid  out  1  out_idx holds an unserviced event
//   out_ready  in   1  consumer accepts out_idx this cycle
//   pending    out  N  captured, not-yet-selected events
//   overflow   out  1  one-cycle pulse: an event merged into a pending bit
// -----------------------------------------------------------------------------
module event_priority_encoder #(
    parameter int N  = 8,
    parameter int W  = 3,
    parameter int RR = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pending,
    output logic         overflow
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t       state_q,   state_d;
    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] out_idx_q, out_idx_d;
    logic [W-1:0] last_q,    last_d;
    logic         overflow_q, overflow_d;

    logic [W-1:0] sel;
    logic         load;
    logic [N-1:0] clear;

    // Winner search: walk downward from last-1, wrapping 0 -> N-1. In fixed
    // mode last is pinned to 0, so the walk starts at N-1 and the highest set
    // index wins; one search serves both modes.
    always_comb begin
        logic found;
        int   idx;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_q) - k + N) % N;
            if (!found && pending_q[idx]) begin
                sel   = W'(idx);
                found = 1'b1;
            end
        end
    end

    assign load = ((state_q == EMPTY) || out_ready) && (pending_q != '0);

    for (genvar gi = 0; gi < N; gi++) begin : g_clear
        assign clear[gi] = load && (sel == W'(gi));
    end

    // A request on the bit being cleared wins and re-arms it as a new event.
    assign pending_d  = (pending_q & ~clear) | req;
    assign overflow_d = |(req & pending_q & ~clear);

    // Output stage: EMPTY/FULL handshake FSM.
    always_comb begin
        state_d   = state_q;
        out_idx_d = out_idx_q;
        last_d    = last_q;
        if (load) begin
            state_d   = FULL;
            out_idx_d = sel;
            last_d    = (RR != 0) ? sel : '0;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            pending_q  <= '0;
            out_idx_q  <= '0;
            last_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            out_idx_q  <= out_idx_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_idx   = out_idx_q;
    assign out_valid = (state_q == FULL);
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/event_priority_encoder.md
# event_priority_encoder

Parametrised, registered priority encoder for N event lines. It latches incoming request pulses into a pending vector and presents one encoded index at a time on a valid/ready output. Once the index has been selected, its pending bit is cleared. Priority is either fixed, with the highest index winning, or round-robin. It sits between raw event or interrupt lines and a single consumer that services one event per handshake.

## Interface
- `N`, default 8: number of request lines; N ≥ 2.
- `W`, default 3: index width; must equal clog2(N).
- `RR`, default 0: priority mode.
  - 0: fixed priority, highest index wins.
  - 1: round-robin.

Ports (name, direction, width, meaning):
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `req` input N: event lines, sampled every cycle; a 1 on bit i marks event i.
- `out_idx` output W: encoded index of the presented event.
- `out_valid` output 1: `out_idx` holds an unserviced event.
- `out_ready` input 1: consumer accepts `out_idx` in this cycle.
- `pending` output N: registered vector of captured, not-yet-selected events.
- `overflow` output 1: one-cycle pulse; an event was merged into an already-pending bit.

## Operation
- State registers: `pending`[N], `out_idx`[W], `out_valid`, `last`[W] (RR only), `overflow`.
- Reset (`rst` = 1 at an edge) clears all of these to 0. `req` in that cycle is ignored.
- Output stage states:
  - EMPTY (`out_valid` = 0).
  - FULL (`out_valid` = 1).
- `load` = (`out_valid` = 0 or `out_ready` = 1) and `pending` ≠ 0.
- `sel` is the winning index chosen from the registered `pending`:
  - RR = 0: highest set index.
  - RR = 1: first set bit searching downward from `last`−1, wrapping from 0 to N−1.
  - The reset value `last` = 0 makes the first RR search start at N−1.
- On `load`:
  - `out_idx` ← `sel`, `out_valid` ← 1.
  - `pending[sel]` is cleared.
  - RR only: `last` ← `sel`.
- Without `load`:
  - FULL with `out_ready` = 1 gives EMPTY: handshake complete, `out_valid` ← 0.
  - FULL with `out_ready` = 0 holds `out_idx` stable.
- Pending update: `pending` ← (`pending` & ~clear) | `req`.
  - clear is the one-hot of `sel` when `load`, otherwise 0.
  - If `req[sel]` is 1 in the same cycle as the clear of bit `sel`, `req` wins and the bit stays pending as a new event.
- `overflow` ← 1 for one cycle if any `req[i]` = 1 while `pending[i]` = 1 and bit i is not being cleared that edge; otherwise 0. The duplicate event is merged and lost.
- `out_ready` while EMPTY has no effect.
- `out_idx` keeps its last value when EMPTY and is don't-care to the consumer.

## Timing
- Latency from a `req` pulse in cycle t (output EMPTY, `pending` = 0):
  - `pending` set after edge t.
  - `out_valid` = 1 with the index after edge t+1, i.e. 2 edges.
- Throughput: one event per cycle while `out_ready` is held at 1 and `pending` ≠ 0. The handshake and the next load occur at the same edge.
- `pending` reflects the clear at the same edge that `out_idx` loads.
- All outputs are registered; there is no combinational path from `req` or `out_ready` to any output.
- Reset mid-operation: the next cycle shows `out_valid` = 0, `pending` = 0 and `overflow` = 0, regardless of any handshake in progress.

## Test plan
- Fixed priority (N = 8, RR = 0), `out_ready` = 1:
  - Stimulus: `req` = 8'b10000001 for one cycle.
  - Required: `out_idx` = 7 valid 2 edges later, then `out_idx` = 0 in the next cycle, then `out_valid` = 0.
  - Required: `pending` steps 0x81 → 0x01 → 0x00.
- Backpressure:
  - Stimulus: same pulse with `out_ready` = 0 for 5 cycles, then 1.
  - Required: `out_idx` = 7 held stable with `out_valid` = 1 and `pending` = 0x01 throughout the stall.
  - Required: after `out_ready` rises, 0 is presented on the next cycle.
- Round-robin (RR = 1), `out_ready` = 1:
  - Stimulus: `req` = 0x81 held as a level.
  - Required: `out_idx` alternates 7, 0, 7, 0.
  - Required: the same stimulus with RR = 0 gives 7 every cycle.
- Overflow:
  - Stimulus: `out_ready` = 0, output FULL with index 7, pulse `req[3]` twice, two cycles apart.
  - Required: `overflow` = 1 for exactly the one cycle after the second pulse; `pending[3]` = 1 only once.
  - Required: after release, index 3 is presented once.
- Reset mid-operation:
  - Stimulus: `pending` = 0xFF, FULL, assert `rst` for 1 cycle while `req` = 0x10.
  - Required: next cycle `out_valid` = 0, `pending` = 0x00, `overflow` = 0.
  - Required: a subsequent `req` = 0x10 pulse yields `out_idx` = 4 after 2 edges.
- RR wrap:
  - Stimulus: `req` = 0xFF for one cycle, `out_ready` = 1.
  - Required: order 7, 6, 5, 4, 3, 2, 1, 0.
  - Required: a following `req` = 0xFF pulse starts again at 7, since `last` = 0 wraps to N−1.
